// File: rtl/fifo_rr_dequeue_pkg.sv
// Shared constants and helpers for the round-robin FIFO dequeue stage.
package fifo_rr_dequeue_pkg;

  localparam int BUF_DEPTH = 2;

  typedef logic [1:0] cnt_t;

  function automatic cnt_t nextCount(input cnt_t cnt, input logic push, input logic pop);
    return cnt + cnt_t'(push) - cnt_t'(pop);
  endfunction

endpackage

// File: rtl/fifo_rr_dequeue_rr_select.sv
// Combinational round-robin picker: the first eligible queue after lastGrant_i wins,
// found by scanning a doubled copy of the eligible vector so the wrap needs no modulo.
module rr_select #(
  parameter int NUM_QUEUES = 4,
  parameter int QID_WIDTH  = $clog2(NUM_QUEUES)
) (
  input  logic [NUM_QUEUES-1:0] eligible_i,
  input  logic [QID_WIDTH-1:0]  lastGrant_i,
  output logic                  grantValid_o,
  output logic [QID_WIDTH-1:0]  grantIdx_o
);

  localparam int PW = $clog2(2 * NUM_QUEUES);

  logic [2*NUM_QUEUES-1:0] doubled;
  logic [PW-1:0]           pos;
  logic [PW-1:0]           wrapped;

  assign doubled = {eligible_i, eligible_i};

  // Scan farthest-first so the nearest eligible queue is the final assignment.
  always_comb begin
    grantValid_o = 1'b0;
    grantIdx_o   = '0;
    pos          = '0;
    wrapped      = '0;
    for (int k = NUM_QUEUES; k >= 1; k--) begin
      pos     = PW'(lastGrant_i) + PW'(k);
      wrapped = (pos >= PW'(NUM_QUEUES)) ? pos - PW'(NUM_QUEUES) : pos;
      if (doubled[pos]) begin
        grantValid_o = 1'b1;
        grantIdx_o   = QID_WIDTH'(wrapped);
      end
    end
  end

endmodule

// File: rtl/fifo_rr_dequeue.sv
// Round-robin dequeue of several upstream FIFOs into one valid/ready stream,
// registered through a 2-entry skid buffer so m_ready never reaches fifo_rd_en.
module fifo_rr_dequeue
  import fifo_rr_dequeue_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_QUEUES = 4,
  parameter int QID_WIDTH  = $clog2(NUM_QUEUES)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_QUEUES-1:0]            fifo_empty,
  input  logic [NUM_QUEUES*DATA_WIDTH-1:0] fifo_data,
  output logic [NUM_QUEUES-1:0]            fifo_rd_en,
  input  logic [NUM_QUEUES-1:0]            q_enable,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic [DATA_WIDTH-1:0]            m_data,
  output logic [QID_WIDTH-1:0]             m_qid
);

  logic [NUM_QUEUES-1:0] eligible;
  logic                  grantValid;
  logic [QID_WIDTH-1:0]  grantIdx;
  logic [DATA_WIDTH-1:0] grantData;
  logic                  push;
  logic                  pop;

  logic [QID_WIDTH-1:0]  lastGrant_q, lastGrant_d;
  cnt_t                  cnt_q, cnt_d;
  logic                  rdPtr_q, rdPtr_d;
  logic                  wrPtr_q, wrPtr_d;
  logic [DATA_WIDTH-1:0] bufData_q [BUF_DEPTH];
  logic [QID_WIDTH-1:0]  bufQid_q  [BUF_DEPTH];

  assign eligible = ~fifo_empty & q_enable;

  rr_select #(
    .NUM_QUEUES (NUM_QUEUES),
    .QID_WIDTH  (QID_WIDTH)
  ) u_rr_select (
    .eligible_i   (eligible),
    .lastGrant_i  (lastGrant_q),
    .grantValid_o (grantValid),
    .grantIdx_o   (grantIdx)
  );

  // Outputs are forced quiet while reset is held, not just after the reset edge.
  assign push    = grantValid && (cnt_q < cnt_t'(BUF_DEPTH)) && !rst;
  assign m_valid = (cnt_q != '0) && !rst;
  assign m_data  = rst ? '0 : bufData_q[rdPtr_q];
  assign m_qid   = rst ? '0 : bufQid_q[rdPtr_q];
  assign pop     = m_valid && m_ready;

  always_comb begin
    fifo_rd_en = '0;
    grantData  = '0;
    for (int i = 0; i < NUM_QUEUES; i++) begin
      if (grantIdx == QID_WIDTH'(i)) begin
        fifo_rd_en[i] = push;
        grantData     = fifo_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    lastGrant_d = push ? grantIdx : lastGrant_q;
    cnt_d       = nextCount(cnt_q, push, pop);
    rdPtr_d     = rdPtr_q ^ pop;
    wrPtr_d     = wrPtr_q ^ push;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lastGrant_q <= QID_WIDTH'(NUM_QUEUES - 1);
      cnt_q       <= '0;
      rdPtr_q     <= 1'b0;
      wrPtr_q     <= 1'b0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        bufData_q[i] <= '0;
        bufQid_q[i]  <= '0;
      end
    end else begin
      lastGrant_q <= lastGrant_d;
      cnt_q       <= cnt_d;
      rdPtr_q     <= rdPtr_d;
      wrPtr_q     <= wrPtr_d;
      if (push) begin
        bufData_q[wrPtr_q] <= grantData;
        bufQid_q[wrPtr_q]  <= grantIdx;
      end
    end
  end

endmodule

// File: tb/tb_fifo_rr_dequeue.sv
// Directed bench for fifo_rr_dequeue: models four upstream FIFOs as queues and
// checks rd strobes and output words cycle by cycle against hand-computed tables.
module tb_fifo_rr_dequeue;

  logic        clk;
  logic        rst;
  logic [3:0]  fifo_empty;
  logic [31:0] fifo_data;
  logic [3:0]  fifo_rd_en;
  logic [3:0]  q_enable;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_data;
  logic [1:0]  m_qid;

  typedef struct {
    logic       rst;
    logic       rdy;
    logic [3:0] rd;
    logic       valid;
    logic       chk;
    logic [7:0] data;
    logic [1:0] qid;
  } vec_t;

  logic [7:0] qs [4][$];
  vec_t       vecs [$];
  logic [3:0] rdEnSeen;
  int         assertCount = 0;
  int         failCount   = 0;

  fifo_rr_dequeue #(
    .DATA_WIDTH (8),
    .NUM_QUEUES (4),
    .QID_WIDTH  (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd_en (fifo_rd_en),
    .q_enable   (q_enable),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_qid      (m_qid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic refreshInputs();
    for (int i = 0; i < 4; i++) begin
      fifo_empty[i]        = (qs[i].size() == 0);
      fifo_data[i*8 +: 8]  = (qs[i].size() != 0) ? qs[i][0] : 8'h00;
    end
  endtask

  task automatic loadQueue(input int q, input logic [7:0] w);
    qs[q].push_back(w);
    refreshInputs();
  endtask

  // One clock: upstream FIFOs pop whatever strobe was high just before the edge.
  task automatic applyStimulus();
    rdEnSeen = fifo_rd_en;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++)
      if (rdEnSeen[i] && qs[i].size() != 0) void'(qs[i].pop_front());
    refreshInputs();
    @(negedge clk);
  endtask

  function automatic void addVec(input logic r, input logic rdy, input logic [3:0] rd,
                                 input logic v, input logic [7:0] d, input logic [1:0] q);
    vec_t x;
    x.rst = r; x.rdy = rdy; x.rd = rd; x.valid = v; x.chk = v | r; x.data = d; x.qid = q;
    vecs.push_back(x);
  endfunction

  task automatic runVectors(input string tag);
    foreach (vecs[i]) begin
      rst     = vecs[i].rst;
      m_ready = vecs[i].rdy;
      #1;
      checkOutput($sformatf("%s[%0d] rd_en", tag, i), 32'(fifo_rd_en), 32'(vecs[i].rd));
      checkOutput($sformatf("%s[%0d] m_valid", tag, i), 32'(m_valid), 32'(vecs[i].valid));
      if (vecs[i].chk) begin
        checkOutput($sformatf("%s[%0d] m_data", tag, i), 32'(m_data), 32'(vecs[i].data));
        checkOutput($sformatf("%s[%0d] m_qid", tag, i), 32'(m_qid), 32'(vecs[i].qid));
      end
      applyStimulus();
    end
    vecs.delete();
  endtask

  initial begin
    rst      = 1'b1;
    m_ready  = 1'b0;
    q_enable = 4'hF;
    refreshInputs();
    @(negedge clk);

    addVec(1, 0, 4'h0, 0, 8'h00, 0);
    addVec(1, 0, 4'h0, 0, 8'h00, 0);
    runVectors("reset");

    for (int i = 0; i < 10; i++) addVec(0, 1, 4'h0, 0, 8'h00, 0);
    runVectors("idle");

    for (int q = 0; q < 4; q++) loadQueue(q, 8'(q));
    for (int q = 0; q < 4; q++) loadQueue(q, 8'(8'h10 + q));
    addVec(0, 1, 4'h1, 0, 8'h00, 0);
    addVec(0, 1, 4'h2, 1, 8'h00, 0);
    addVec(0, 1, 4'h4, 1, 8'h01, 1);
    addVec(0, 1, 4'h8, 1, 8'h02, 2);
    addVec(0, 1, 4'h1, 1, 8'h03, 3);
    addVec(0, 1, 4'h2, 1, 8'h10, 0);
    addVec(0, 1, 4'h4, 1, 8'h11, 1);
    addVec(0, 1, 4'h8, 1, 8'h12, 2);
    addVec(0, 1, 4'h0, 1, 8'h13, 3);
    addVec(0, 1, 4'h0, 0, 8'h00, 0);
    runVectors("rr");

    loadQueue(0, 8'h40); loadQueue(0, 8'h41);
    loadQueue(1, 8'h50); loadQueue(1, 8'h51);
    loadQueue(2, 8'h60); loadQueue(3, 8'h70);
    addVec(0, 0, 4'h1, 0, 8'h00, 0);
    addVec(0, 0, 4'h2, 1, 8'h40, 0);
    addVec(0, 0, 4'h0, 1, 8'h40, 0);
    addVec(0, 0, 4'h0, 1, 8'h40, 0);
    addVec(0, 0, 4'h0, 1, 8'h40, 0);
    addVec(0, 0, 4'h0, 1, 8'h40, 0);
    addVec(0, 1, 4'h0, 1, 8'h40, 0);
    addVec(0, 1, 4'h4, 1, 8'h50, 1);
    addVec(0, 1, 4'h8, 1, 8'h60, 2);
    addVec(0, 1, 4'h1, 1, 8'h70, 3);
    addVec(0, 1, 4'h2, 1, 8'h41, 0);
    addVec(0, 1, 4'h0, 1, 8'h51, 1);
    addVec(0, 1, 4'h0, 0, 8'h00, 0);
    runVectors("bp");

    for (int i = 0; i < 5; i++) loadQueue(2, 8'(8'hA0 + i));
    addVec(0, 1, 4'h4, 0, 8'h00, 0);
    addVec(0, 1, 4'h4, 1, 8'hA0, 2);
    addVec(0, 1, 4'h4, 1, 8'hA1, 2);
    addVec(0, 1, 4'h4, 1, 8'hA2, 2);
    addVec(0, 1, 4'h4, 1, 8'hA3, 2);
    addVec(0, 1, 4'h0, 1, 8'hA4, 2);
    addVec(0, 1, 4'h0, 0, 8'h00, 0);
    runVectors("q2only");

    q_enable = 4'b1011;
    loadQueue(0, 8'hD0); loadQueue(0, 8'hD1);
    loadQueue(1, 8'hE0); loadQueue(1, 8'hE1);
    loadQueue(2, 8'hF0); loadQueue(2, 8'hF1);
    loadQueue(3, 8'h90); loadQueue(3, 8'h91);
    addVec(0, 1, 4'h8, 0, 8'h00, 0);
    addVec(0, 1, 4'h1, 1, 8'h90, 3);
    addVec(0, 1, 4'h2, 1, 8'hD0, 0);
    addVec(0, 1, 4'h8, 1, 8'hE0, 1);
    addVec(0, 1, 4'h1, 1, 8'h91, 3);
    addVec(0, 1, 4'h2, 1, 8'hD1, 0);
    addVec(0, 1, 4'h0, 1, 8'hE1, 1);
    addVec(0, 1, 4'h0, 0, 8'h00, 0);
    runVectors("mask");
    checkOutput("mask q2 untouched", 32'(qs[2].size()), 32'd2);
    q_enable = 4'hF;

    loadQueue(0, 8'h20); loadQueue(1, 8'h21); loadQueue(3, 8'h23);
    addVec(0, 0, 4'h4, 0, 8'h00, 0);
    addVec(0, 0, 4'h8, 1, 8'hF0, 2);
    addVec(1, 0, 4'h0, 0, 8'h00, 0);
    addVec(0, 0, 4'h1, 0, 8'h00, 0);
    addVec(0, 0, 4'h2, 1, 8'h20, 0);
    addVec(0, 1, 4'h0, 1, 8'h20, 0);
    addVec(0, 1, 4'h4, 1, 8'h21, 1);
    addVec(0, 1, 4'h0, 1, 8'hF1, 2);
    addVec(0, 1, 4'h0, 0, 8'h00, 0);
    runVectors("midrst");

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
